mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-port byte-addressed Memory between the instruction-fetch port and the load/store (data) port of the core.
- Data priority, with a starvation limit that guarantees fetch progress.
- One access per cycle; registered response one cycle after acceptance.
- Misalignment detection; load sign/zero extension (LB/LH/LW/LBU/LHU); drives Memory's write_length for SB/SH/SW.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose before it is forced a grant; 0 = fetch always wins.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  fetch request
i_req_ready  out  1  fetch accepted this cycle
i_addr  in  32  fetch byte address
i_rsp_valid  out  1  fetch response strobe (one cycle)
i_rsp_data  out  32  instruction word
i_rsp_err  out  1  fetch misaligned
d_req_valid  in  1  data request
d_req_ready  out  1  data accepted this cycle
d_addr  in  32  data byte address
d_we  in  1  1 = store, 0 = load
d_size  in  2  0 byte, 1 half, 2 word, 3 illegal
d_unsigned  in  1  zero-extend load
d_wdata  in  32  store data, LSB-aligned
d_rsp_valid  out  1  data response strobe (one cycle)
d_rsp_data  out  32  extended load data; 0 for stores and errors
d_rsp_err  out  1  misaligned or illegal size
mem_address  out  32  to Memory.address
mem_wr_data  out  32  to Memory.wr_data
mem_wr_enable  out  1  to Memory.wr_enable
mem_write_length  out  3  to Memory.write_length (0/1/2)
mem_read_data  in  32  from Memory.read_data (combinational, bytes addr..addr+3, little-endian)

Behaviour:
- Reset (async, rst_n=0): all *_rsp_valid, *_rsp_data, *_rsp_err = 0; starve_cnt = 0. Pending responses are discarded, not replayed.
- Grant (combinational, same cycle):
  - Only one valid: that port wins.
  - Both valid: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - Winner sees ready=1; loser sees ready=0 and must hold its request stable.
- starve_cnt, updated at posedge:
  - i_req_valid & !grant_i: +1, saturating at STARVE_LIMIT.
  - Otherwise: cleared to 0.
- Memory drive in the grant cycle:
  - mem_address = winner address.
  - Fetch: mem_write_length = 2, mem_wr_enable = 0.
  - Data: mem_write_length = d_size, mem_wr_data = d_wdata, mem_wr_enable = d_we & !misaligned.
  - Idle: mem_wr_enable = 0, mem_address = 0.
  - Memory commits stores at the posedge ending the grant cycle.
- Misalignment:
  - Data: half with addr[0]=1, word with addr[1:0]≠0, or size 3.
  - Fetch: addr[1:0]≠0.
  - A misaligned request is still accepted and consumes the slot. No write occurs. The response carries err=1, data=0.
- Response, registered at the posedge of the grant cycle, valid the next cycle for exactly one cycle:
  - Fetch: data = mem_read_data.
  - Load: byte → [7:0], half → [15:0], extended by bit 7/15 unless d_unsigned; word → as-is.
  - Store: data = 0.
  - There is no response back-pressure; requesters must sink responses.
- Throughput: back-to-back grants are allowed every cycle. A response and a new grant may coincide. A store followed by a load to the same address on the next cycle returns the new data.

Decomposition:
- Shared constants go in rtl/utilities.v: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2, plus the misalignment predicate macro.
- One combinational sub-module, load_extend (mem_read_data, size, unsigned → 32-bit result).
- The arbiter holds the grant logic, starve_cnt and the response registers.

Test Plan:
- SW 0x12345678 @8, then LW @8 → 0x12345678; LB @11 → 0x00000012; LH @8 → 0x00005678.
- SB 0xF0 @9, then LB @9 → 0xFFFFFFF0; LBU @9 → 0x000000F0; LW @8 → 0x1234F078.
- SH 0x8001 @12, then LH @12 → 0xFFFF8001; LHU @12 → 0x00008001.
- Both valid for 6 cycles, STARVE_LIMIT=4 → d_req_ready on cycles 0–3, i_req_ready on cycle 4, data again on cycle 5; each i_rsp/d_rsp_valid follows its grant by one cycle.
- LH @3 → d_rsp_err=1, data 0. SW 0xDEADBEEF @6 → err=1, and LW @4 is unchanged. Fetch @2 → i_rsp_err=1.
- Accept LW @8, pull rst_n low mid-next-cycle → d_rsp_valid=0 immediately, starve_cnt=0, no response after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared access-size encodings and alignment predicates for the memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  localparam logic [2:0] FETCH_LEN = 3'd2;

  // Data access is misaligned for odd halves, non-word-aligned words, or the illegal size.
  function automatic logic d_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'd0);
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic i_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'd0);
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// Selects the low byte/half/word of a memory read and sign- or zero-extends it.
module mem_arbiter_load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (size)
      SIZE_BYTE: result = {{24{~is_unsigned & rdata[7]}}, rdata[7:0]};
      SIZE_HALF: result = {{16{~is_unsigned & rdata[15]}}, rdata[15:0]};
      SIZE_WORD: result = rdata;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between fetch and load/store ports; data has
// priority, but a fetch that has lost STARVE_LIMIT cycles in a row is forced through.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic [2:0]  mem_write_length,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             grant_i;
  logic             grant_d;
  logic             i_mis;
  logic             d_mis;
  logic [31:0]      ext_data;

  // Same-cycle grant; with STARVE_LIMIT=0 the counter sits at the limit so fetch always wins.
  always_comb begin
    starve_hit = (starve_cnt == CNT_MAX);
    grant_i    = i_req_valid & (~d_req_valid | starve_hit);
    grant_d    = d_req_valid & ~grant_i;
    i_mis      = i_misaligned(i_addr[1:0]);
    d_mis      = d_misaligned(d_size, d_addr[1:0]);
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // Memory drive for the winner of this cycle.
  always_comb begin
    mem_address      = '0;
    mem_wr_data      = '0;
    mem_wr_enable    = 1'b0;
    mem_write_length = 3'd0;
    if (grant_i) begin
      mem_address      = i_addr;
      mem_write_length = FETCH_LEN;
    end else if (grant_d) begin
      mem_address      = d_addr;
      mem_wr_data      = d_wdata;
      mem_wr_enable    = d_we & ~d_mis;
      mem_write_length = {1'b0, d_size};
    end
  end

  mem_arbiter_load_extend u_load_extend (
    .rdata       (mem_read_data),
    .size        (d_size),
    .is_unsigned (d_unsigned),
    .result      (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (i_req_valid & ~grant_i) begin
      if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Responses are captured at the end of the grant cycle and strobe for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      i_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
    end else begin
      i_rsp_valid <= grant_i;
      i_rsp_data  <= (grant_i & ~i_mis) ? mem_read_data : '0;
      i_rsp_err   <= grant_i & i_mis;
      d_rsp_valid <= grant_d;
      d_rsp_data  <= (grant_d & ~d_we & ~d_mis) ? ext_data : '0;
      d_rsp_err   <= grant_d & d_mis;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a little-endian byte memory model attached.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        i_req_ready;
  logic [31:0] i_addr = '0;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_wdata = '0;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_wr_data;
  logic        mem_wr_enable;
  logic [2:0]  mem_write_length;
  logic [31:0] mem_read_data;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
    .mem_write_length(mem_write_length), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: byte k initialised to k; combinational read, write at posedge.
  logic [7:0] mem [0:255];
  logic       mem_inited = 1'b0;
  logic [7:0] ma;

  always_comb begin
    ma = mem_address[7:0];
    mem_read_data = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
  end

  always @(posedge clk) begin
    mem_inited <= 1'b1;
    if (!mem_inited) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (mem_wr_enable) begin
      mem[ma] <= mem_wr_data[7:0];
      if (mem_write_length >= 3'd1) mem[ma + 8'd1] <= mem_wr_data[15:8];
      if (mem_write_length == 3'd2) begin
        mem[ma + 8'd2] <= mem_wr_data[23:16];
        mem[ma + 8'd3] <= mem_wr_data[31:24];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a response strobe is seen.
  always @(negedge clk) begin
    exp_t e;
    if (d_rsp_valid) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL d_rsp_unexpected actual=%h required=none", d_rsp_data);
      end else begin
        e = dq.pop_front();
        check("d_rsp_data", d_rsp_data, e.data);
        check("d_rsp_err", 32'(d_rsp_err), 32'(e.err));
        check("d_rsp_cycle", 32'(cyc), e.cyc);
      end
    end
    if (i_rsp_valid) begin
      if (iq.size() == 0) begin
        checks++; failures++;
        $display("FAIL i_rsp_unexpected actual=%h required=none", i_rsp_data);
      end else begin
        e = iq.pop_front();
        check("i_rsp_data", i_rsp_data, e.data);
        check("i_rsp_err", 32'(i_rsp_err), 32'(e.err));
        check("i_rsp_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  task automatic set_data(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
    d_req_valid = 1'b1;
    d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
  endtask

  task automatic data_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ed, input logic ee);
    @(negedge clk);
    set_data(we, sz, uns, a, wd);
    #1;
    check("d_req_ready", 32'(d_req_ready), 32'd1);
    dq.push_back('{data: ed, err: ee, cyc: 32'(cyc + 1)});
  endtask

  task automatic fetch_req(input logic [31:0] a, input logic [31:0] ed, input logic ee);
    @(negedge clk);
    i_req_valid = 1'b1; i_addr = a;
    #1;
    check("i_req_ready", 32'(i_req_ready), 32'd1);
    iq.push_back('{data: ed, err: ee, cyc: 32'(cyc + 1)});
  endtask

  task automatic idle();
    @(negedge clk);
    d_req_valid = 1'b0; i_req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    check("reset_i_rsp_data", i_rsp_data, 32'd0);
    check("reset_i_rsp_err", 32'(i_rsp_err), 32'd0);
    check("reset_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    check("reset_d_rsp_data", d_rsp_data, 32'd0);
    check("reset_d_rsp_err", 32'(d_rsp_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word/byte/half stores and loads, issued back to back.
    data_req(1'b1, 2'd2, 1'b0, 32'd8,  32'h12345678, 32'h0, 1'b0);
    data_req(1'b0, 2'd2, 1'b0, 32'd8,  32'h0, 32'h12345678, 1'b0);
    data_req(1'b0, 2'd0, 1'b0, 32'd11, 32'h0, 32'h00000012, 1'b0);
    data_req(1'b0, 2'd1, 1'b0, 32'd8,  32'h0, 32'h00005678, 1'b0);
    data_req(1'b1, 2'd0, 1'b0, 32'd9,  32'hAAAAAAF0, 32'h0, 1'b0);
    data_req(1'b0, 2'd0, 1'b0, 32'd9,  32'h0, 32'hFFFFFFF0, 1'b0);
    data_req(1'b0, 2'd0, 1'b1, 32'd9,  32'h0, 32'h000000F0, 1'b0);
    data_req(1'b0, 2'd2, 1'b0, 32'd8,  32'h0, 32'h1234F078, 1'b0);
    data_req(1'b1, 2'd1, 1'b0, 32'd12, 32'h55558001, 32'h0, 1'b0);
    data_req(1'b0, 2'd1, 1'b0, 32'd12, 32'h0, 32'hFFFF8001, 1'b0);
    data_req(1'b0, 2'd1, 1'b1, 32'd12, 32'h0, 32'h00008001, 1'b0);
    idle();

    // Misalignment and illegal size.
    data_req(1'b0, 2'd1, 1'b0, 32'd3,  32'h0, 32'h0, 1'b1);
    data_req(1'b1, 2'd2, 1'b0, 32'd6,  32'hDEADBEEF, 32'h0, 1'b1);
    data_req(1'b0, 2'd2, 1'b0, 32'd4,  32'h0, 32'h07060504, 1'b0);
    data_req(1'b0, 2'd3, 1'b0, 32'd0,  32'h0, 32'h0, 1'b1);
    idle();
    fetch_req(32'h20, 32'h23222120, 1'b0);
    fetch_req(32'd2, 32'h0, 1'b1);
    idle();

    // Contention: data wins cycles 0-3, fetch forced on cycle 4, data again on 5.
    repeat (2) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i_req_valid = 1'b1; i_addr = 32'h20;
      set_data(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
      #1;
      check("starve_d_ready", 32'(d_req_ready), (c != 4) ? 32'd1 : 32'd0);
      check("starve_i_ready", 32'(i_req_ready), (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) iq.push_back('{data: 32'h23222120, err: 1'b0, cyc: 32'(cyc + 1)});
      else        dq.push_back('{data: 32'h1234F078, err: 1'b0, cyc: 32'(cyc + 1)});
    end
    idle();
    repeat (3) @(negedge clk);

    // Reset while a response is in flight: it must vanish and not come back.
    @(negedge clk);
    i_req_valid = 1'b1; i_addr = 32'h20;
    set_data(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    #1;
    check("rst_d_ready", 32'(d_req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("rst_pre_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("rst_pre_starve_cnt", 32'(dut.starve_cnt), 32'd1);
    #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    check("rst_d_rsp_data", d_rsp_data, 32'd0);
    check("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("dq_drained", 32'(dq.size()), 32'd0);
    check("iq_drained", 32'(iq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
